result_readout_ctrl: RTL

//  Reader side of the per-frame result RAM, which the energy/MFCC copy path fills.
//  On start, walks num_frames x COEFS_PER_FRAME words from base_addr and streams each word out on a

---
 rtl/result_readout_ctrl_pkg.sv | 22 ++
 rtl/result_readout_ctrl_wait_counter.sv | 33 +++
 rtl/result_readout_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/result_readout_ctrl_pkg.sv
// Shared definitions for the result RAM readout controller: FSM state
// encodings, default frame geometry / RAM latency, and a counter-width helper.
package result_readout_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int unsigned DEF_COEFS_PER_FRAME = 13;
    localparam int unsigned DEF_RD_LATENCY      = 2;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/result_readout_ctrl_wait_counter.sv
// Down-counter used to time the RAM read latency.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : value loaded; over_c rises after load_val enabled cycles
//   cnt_en     : decrement while non-zero
//   over_c     : counter has reached zero (combinational from the register)
module result_readout_ctrl_wait_counter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cnt_en,
    output logic             over_c
);

    logic [WIDTH-1:0] cnt_q;

    // Count register: load wins, otherwise saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign over_c = (cnt_q == '0);

endmodule

// File: rtl/result_readout_ctrl.sv
// Reader side of the per-frame result RAM. On a start pulse it walks
// num_frames x COEFS_PER_FRAME words from base_addr, one outstanding read at a
// time, and streams each word out on a valid/ready port tagged with
// last-coefficient / last-frame flags.
//   clk, rst_n        : clock, async active-low reset
//   readout_en        : start pulse, sampled only in IDLE with base_addr/num_frames
//   result_rd_en/addr : RAM read strobe and address (registered)
//   result_rd_data    : RAM data, valid RD_LATENCY cycles after the strobe
//   out_data/valid    : registered output stream, handshake with out_ready
//   out_last_coef     : word is the last coefficient of its frame
//   out_last_frame    : word belongs to the final frame
//   busy, done        : transfer in progress / 1-cycle completion pulse
module result_readout_ctrl
    import result_readout_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FRAME_WIDTH     = 8,
    parameter int unsigned COEFS_PER_FRAME = DEF_COEFS_PER_FRAME,
    parameter int unsigned RD_LATENCY      = DEF_RD_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   readout_en,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [FRAME_WIDTH-1:0] num_frames,
    output logic                   result_rd_en,
    output logic [ADDR_WIDTH-1:0]  result_rd_addr,
    input  logic [DATA_WIDTH-1:0]  result_rd_data,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last_coef,
    output logic                   out_last_frame,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned COEF_WIDTH = cnt_width(COEFS_PER_FRAME);
    localparam int unsigned WAIT_WIDTH = cnt_width(RD_LATENCY);
    localparam logic [COEF_WIDTH-1:0] LAST_COEF = COEF_WIDTH'(COEFS_PER_FRAME - 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = WAIT_WIDTH'(RD_LATENCY - 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [FRAME_WIDTH-1:0] frames_q, frames_d;
    logic [FRAME_WIDTH-1:0] frame_q, frame_d;
    logic [COEF_WIDTH-1:0]  coef_q, coef_d;
    logic                   wait_over_c;

    // Counts the WAIT cycles; loaded during ISSUE so WAIT lasts RD_LATENCY cycles.
    result_readout_ctrl_wait_counter #(
        .WIDTH (WAIT_WIDTH)
    ) u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == ST_ISSUE),
        .load_val (WAIT_LOAD),
        .cnt_en   (state_q == ST_WAIT),
        .over_c   (wait_over_c)
    );

    // State and walk counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            frames_q <= '0;
            frame_q  <= '0;
            coef_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            frames_q <= frames_d;
            frame_q  <= frame_d;
            coef_q   <= coef_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        frames_d = frames_q;
        frame_d  = frame_q;
        coef_d   = coef_q;
        unique case (state_q)
            ST_IDLE: begin
                if (readout_en) begin
                    addr_d   = base_addr;
                    frames_d = num_frames;
                    frame_d  = '0;
                    coef_d   = '0;
                    state_d  = (num_frames == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_over_c) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                // Address wraps silently at the top of the RAM.
                addr_d = ADDR_WIDTH'(addr_q + 1'b1);
                if (coef_q == LAST_COEF) begin
                    coef_d  = '0;
                    frame_d = FRAME_WIDTH'(frame_q + 1'b1);
                end else begin
                    coef_d  = COEF_WIDTH'(coef_q + 1'b1);
                end
                // The flags still describe the word just handed off.
                state_d = (out_last_coef && out_last_frame) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output registers, driven from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_rd_en   <= 1'b0;
            result_rd_addr <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last_coef  <= 1'b0;
            out_last_frame <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            result_rd_en <= (state_d == ST_ISSUE);
            out_valid    <= (state_d == ST_PRESENT);
            busy         <= (state_d != ST_IDLE);
            done         <= (state_d == ST_DONE);
            // Address holds its last value outside ISSUE.
            if (state_d == ST_ISSUE) begin
                result_rd_addr <= addr_d;
            end
            // Capture the word on the last WAIT cycle; held through PRESENT.
            if ((state_q == ST_WAIT) && wait_over_c) begin
                out_data       <= result_rd_data;
                out_last_coef  <= (coef_q == LAST_COEF);
                out_last_frame <= (frame_q == FRAME_WIDTH'(frames_q - 1'b1));
            end
        end
    end

endmodule
